// File: rtl/fir_stream_filter_if.sv
// Streaming FIR bus: sample input/output handshakes, coefficient loading and flush control.
// The filter takes the slave modport; the sample source / sink side takes master.
interface fir_stream_filter_if #(
  parameter int TAPS       = 8,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 16
);
  localparam int ADDR_WIDTH = $clog2(TAPS);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_sat;
  logic                         coef_we;
  logic [ADDR_WIDTH-1:0]        coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_wdata;
  logic                         coef_swap;
  logic                         flush;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, coef_swap, flush,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, coef_swap, flush,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fir_stream_filter.sv
// Streaming signed direct-form FIR with double-buffered coefficients, a 4-stage stallable
// pipeline (delay line, products, sum, round/saturate) and valid/ready handshakes.
module fir_stream_filter #(
  parameter int TAPS       = 8,
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_BITS  = 15
) (
  input logic               clk,
  input logic               rst_n,
  fir_stream_filter_if.slave bus
);
  localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS);
  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;
  localparam int RND_WIDTH  = ACC_WIDTH + 1;
  localparam logic signed [RND_WIDTH-1:0] HALF    = RND_WIDTH'((64'(1) << FRAC_BITS) >> 1);
  localparam logic signed [RND_WIDTH-1:0] OUT_MAX = RND_WIDTH'((64'(1) << (OUT_WIDTH - 1)) - 64'(1));
  localparam logic signed [RND_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [DATA_WIDTH-1:0] x           [TAPS];
  logic signed [COEF_WIDTH-1:0] shadow      [TAPS];
  logic signed [COEF_WIDTH-1:0] shadow_next [TAPS];
  logic signed [COEF_WIDTH-1:0] active      [TAPS];
  logic signed [PROD_WIDTH-1:0] prod        [TAPS];
  logic signed [ACC_WIDTH-1:0]  sum_comb;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [RND_WIDTH-1:0]  rounded;
  logic signed [RND_WIDTH-1:0]  shifted;
  logic                         s0_valid;
  logic                         s1_valid;
  logic                         s2_valid;
  logic                         adv;
  logic                         accept;

  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv && !bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;

  // A swap in the same cycle as a write must see the freshly written coefficient.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      shadow_next[k] = shadow[k];
      if (bus.coef_we && (32'(bus.coef_addr) == k)) begin
        shadow_next[k] = bus.coef_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      shadow <= shadow_next;
      if (bus.coef_swap) begin
        active <= shadow_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      s0_valid <= 1'b0;
    end else if (bus.flush) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      s0_valid <= 1'b0;
    end else if (adv) begin
      s0_valid <= accept;
      if (accept) begin
        x[0] <= bus.in_data;
        for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
      end
    end
  end

  // All products of one output are captured together, so an output never mixes banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) prod[k] <= '0;
      s1_valid <= 1'b0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= s0_valid;
      for (int k = 0; k < TAPS; k++) begin
        prod[k] <= PROD_WIDTH'(x[k]) * PROD_WIDTH'(active[k]);
      end
    end
  end

  always_comb begin
    sum_comb = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum_comb = sum_comb + ACC_WIDTH'(prod[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      s2_valid <= 1'b0;
    end else if (bus.flush) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      acc      <= sum_comb;
      s2_valid <= s1_valid;
    end
  end

  // One guard bit above the accumulator keeps the rounding add from wrapping.
  assign rounded = RND_WIDTH'(acc) + HALF;
  assign shifted = rounded >>> FRAC_BITS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= 1'b0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (adv) begin
      bus.out_valid <= s2_valid;
      if (s2_valid) begin
        if (shifted > OUT_MAX) begin
          bus.out_data <= OUT_WIDTH'(OUT_MAX);
          bus.out_sat  <= 1'b1;
        end else if (shifted < OUT_MIN) begin
          bus.out_data <= OUT_WIDTH'(OUT_MIN);
          bus.out_sat  <= 1'b1;
        end else begin
          bus.out_data <= OUT_WIDTH'(shifted);
          bus.out_sat  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fir_stream_filter.sv
// Bench for fir_stream_filter: directed and randomized streams scored against a plain
// arithmetic FIR model (sample history times active coefficients, rounded and clamped).
module tb_fir_stream_filter;
  localparam int TAPS       = 8;
  localparam int DATA_WIDTH = 16;
  localparam int COEF_WIDTH = 16;
  localparam int OUT_WIDTH  = 16;
  localparam int FRAC_BITS  = 15;
  localparam int ADDR_WIDTH = $clog2(TAPS);
  localparam longint OMAX   = (longint'(1) << (OUT_WIDTH - 1)) - 1;
  localparam longint OMIN   = -(longint'(1) << (OUT_WIDTH - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_stream_filter_if #(
    .TAPS(TAPS), .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH), .OUT_WIDTH(OUT_WIDTH)
  ) bus ();

  fir_stream_filter #(
    .TAPS(TAPS), .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH),
    .OUT_WIDTH(OUT_WIDTH), .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    longint data;
    bit     sat;
    int     edge_idx;
  } exp_t;

  exp_t   exp_q[$];
  longint hist[$];
  longint shadow_m [TAPS];
  longint active_m [TAPS];
  longint coef_set [TAPS];
  int     step          = 0;
  int     accepts       = 0;
  int     errors        = 0;
  int     checks        = 0;
  bit     check_latency = 1'b0;
  longint last_out      = 0;

  task automatic check_output(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint sext_data(input longint v);
    logic signed [DATA_WIDTH-1:0] t;
    t = DATA_WIDTH'(v);
    return longint'(t);
  endfunction

  function automatic longint sext_coef(input longint v);
    logic signed [COEF_WIDTH-1:0] t;
    t = COEF_WIDTH'(v);
    return longint'(t);
  endfunction

  // y(n) = sum x(n-k) * w[k]; round half up, arithmetic shift, clamp to the output range.
  function automatic void model_accept(input longint sample, input int edge_idx);
    longint acc = 0;
    longint r;
    exp_t   e;
    hist.push_front(sample);
    if (hist.size() > TAPS) void'(hist.pop_back());
    foreach (hist[k]) acc += hist[k] * active_m[k];
    r = (acc + ((longint'(1) << FRAC_BITS) >>> 1)) >>> FRAC_BITS;
    e.sat = 1'b0;
    if (r > OMAX) begin
      r = OMAX;
      e.sat = 1'b1;
    end else if (r < OMIN) begin
      r = OMIN;
      e.sat = 1'b1;
    end
    e.data     = r;
    e.edge_idx = edge_idx;
    exp_q.push_back(e);
    accepts++;
  endfunction

  // One clock: drive at the falling edge, observe 1 ns later, update the model for the next rising edge.
  task automatic apply_stimulus(input bit iv, input longint din, input bit ordy, input bit we,
                                input int addr, input longint wdata, input bit swap, input bit fl);
    exp_t e;
    @(negedge clk);
    bus.in_valid   = iv;
    bus.in_data    = DATA_WIDTH'(din);
    bus.out_ready  = ordy;
    bus.coef_we    = we;
    bus.coef_addr  = ADDR_WIDTH'(addr);
    bus.coef_wdata = COEF_WIDTH'(wdata);
    bus.coef_swap  = swap;
    bus.flush      = fl;
    #1;
    if (fl) check_output("in_ready_flush", longint'(bus.in_ready), 0);
    else if (ordy) check_output("in_ready_open", longint'(bus.in_ready), 1);
    if (bus.out_valid && ordy && !fl) begin
      if (exp_q.size() == 0) begin
        check_output("spurious_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("out_data", longint'(bus.out_data), e.data);
        check_output("out_sat", longint'(bus.out_sat), longint'(e.sat));
        if (check_latency) check_output("latency", longint'(step - 1 - e.edge_idx), 3);
        last_out = longint'(bus.out_data);
      end
    end
    if (fl) begin
      hist.delete();
      exp_q.delete();
    end
    if (we && addr < TAPS) shadow_m[addr] = sext_coef(wdata);
    if (swap) active_m = shadow_m;
    if (iv && bus.in_ready && !fl) model_accept(sext_data(din), step);
    step++;
  endtask

  task automatic set_idle();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    bus.coef_swap  = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_out_valid", longint'(bus.out_valid), 0);
    check_output("rst_out_data", longint'(bus.out_data), 0);
    check_output("rst_out_sat", longint'(bus.out_sat), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hist.delete();
    exp_q.delete();
    foreach (shadow_m[k]) begin
      shadow_m[k] = 0;
      active_m[k] = 0;
    end
  endtask

  // The final write shares its cycle with the swap.
  task automatic load_coefs();
    for (int k = 0; k < TAPS; k++) begin
      apply_stimulus(1'b0, 0, 1'b1, 1'b1, k, coef_set[k], k == TAPS - 1, 1'b0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      apply_stimulus(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
      n++;
    end
    check_output("drain_empty", longint'(exp_q.size()), 0);
    repeat (2) apply_stimulus(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic run_impulse();
    check_latency = 1'b1;
    apply_stimulus(1'b1, 32767, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (TAPS + 1) apply_stimulus(1'b1, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    drain();
    check_latency = 1'b0;
  endtask

  task automatic impulse_coefs();
    for (int k = 0; k < TAPS; k++) coef_set[k] = (k + 1) * 4096;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int guard;
    set_idle();
    do_reset();

    // Impulse response reproduces the coefficients scaled by 32767/32768.
    impulse_coefs();
    load_coefs();
    run_impulse();

    // Step response settles exactly at the input level.
    foreach (coef_set[k]) coef_set[k] = 'h1000;
    load_coefs();
    repeat (12) apply_stimulus(1'b1, 'h4000, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    drain();
    check_output("step_final", last_out, 16384);

    // Saturation at both rails.
    foreach (coef_set[k]) coef_set[k] = 'h7FFF;
    load_coefs();
    repeat (10) apply_stimulus(1'b1, 'h7FFF, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    drain();
    check_output("sat_pos", last_out, 32767);
    repeat (10) apply_stimulus(1'b1, 'h8000, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    drain();
    check_output("sat_neg", last_out, -32768);

    // Random backpressure: 30% out_ready, 200 accepted samples.
    foreach (coef_set[k]) coef_set[k] = longint'($urandom_range(0, 8191)) - 4096;
    load_coefs();
    accepts = 0;
    guard   = 0;
    while (accepts < 200 && guard < 5000) begin
      apply_stimulus($urandom_range(0, 9) < 8, longint'($urandom_range(0, 65535)),
                     $urandom_range(0, 9) < 3, 1'b0, 0, 0, 1'b0, 1'b0);
      guard++;
    end
    check_output("bp_accepted", longint'(accepts), 200);
    drain();

    // Coefficient swap while streaming: each output must come from one bank only.
    foreach (coef_set[k]) coef_set[k] = longint'($urandom_range(0, 65535)) - 32768;
    load_coefs();
    for (int i = 0; i < 40; i++) begin
      if (i >= 10 && i < 10 + TAPS)
        apply_stimulus(1'b1, longint'($urandom_range(0, 65535)), 1'b1, 1'b1, i - 10,
                       longint'($urandom_range(0, 65535)), i == 9 + TAPS, 1'b0);
      else
        apply_stimulus(1'b1, longint'($urandom_range(0, 65535)), 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    drain();

    // Flush with three samples in flight, then a clean impulse.
    impulse_coefs();
    load_coefs();
    repeat (3) apply_stimulus(1'b1, longint'($urandom_range(0, 65535)), 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1234, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1);
    check_output("flush_no_valid", longint'(bus.out_valid), 0);
    repeat (4) apply_stimulus(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    run_impulse();

    // Flush discarding a stalled output.
    repeat (5) apply_stimulus(1'b1, longint'($urandom_range(0, 65535)), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    check_output("stall_pending", longint'(bus.out_valid), 1);
    apply_stimulus(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    repeat (4) apply_stimulus(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    run_impulse();

    // Reset mid-stream, then a clean impulse.
    repeat (3) apply_stimulus(1'b1, longint'($urandom_range(0, 65535)), 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    do_reset();
    repeat (4) apply_stimulus(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    impulse_coefs();
    load_coefs();
    run_impulse();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
